// File: rtl/block_lock_ctrl.sv
// Purpose : 64b/66b block-lock FSM (HUNT/SLIP/LOCKED); bitslip requests and descrambler gating.
// Latency : rx_bitslip/block_lock one edge after the deciding header; descrambler_en zero-latency.
// Backpr. : none; header_valid low simply stalls the hunt/window counters (SLIP timer keeps running).
//
// Ports:
//   USER_CLK        block clock (SerDes RX domain)
//   SYSTEM_RESET    synchronous, active-high reset
//   sync_header     2-bit sync header of the current block (01/10 valid, 00/11 invalid)
//   header_valid    sync_header is meaningful this cycle
//   rx_bitslip      one-cycle request for a 1-bit slip in the gearbox
//   block_lock      registered lock status
//   descrambler_en  block_lock & header_valid, combinational
//   slip_cnt        saturating count of issued bitslips          (BLOCK_LOCK_STATS_EN only)
//   lock_loss_cnt   saturating count of LOCKED->SLIP transitions (BLOCK_LOCK_STATS_EN only)
//
// Build option: define BLOCK_LOCK_STATS_EN to add the statistics counters and their ports.

module block_lock_ctrl #(
    parameter int unsigned LOCK_COUNT = 64,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned BAD_MAX    = 16,
    parameter int unsigned SLIP_WAIT  = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             USER_CLK,
    input  logic             SYSTEM_RESET,
    input  logic [1:0]       sync_header,
    input  logic             header_valid,
    output logic             rx_bitslip,
    output logic             block_lock,
`ifdef BLOCK_LOCK_STATS_EN
    output logic             descrambler_en,
    output logic [CNT_W-1:0] slip_cnt,
    output logic [CNT_W-1:0] lock_loss_cnt
`else
    output logic             descrambler_en
`endif
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WIN_W  = $clog2(WINDOW + 1);
    localparam int unsigned BAD_W  = $clog2(BAD_MAX + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              block_lock_q, block_lock_d;
    logic              rx_bitslip_q, rx_bitslip_d;

    // A valid sync header has exactly one bit set.
    logic hdr_ok;
    logic good_hdr;
    logic bad_hdr;

    assign hdr_ok   = sync_header[1] ^ sync_header[0];
    assign good_hdr = header_valid & hdr_ok;
    assign bad_hdr  = header_valid & ~hdr_ok;

    // ------------------------------------------------------------------
    // State register (also holds the counters and the registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            state_q      <= ST_HUNT;
            good_cnt_q   <= '0;
            win_cnt_q    <= '0;
            bad_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            block_lock_q <= 1'b0;
            rx_bitslip_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            win_cnt_q    <= win_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            block_lock_q <= block_lock_d;
            rx_bitslip_q <= rx_bitslip_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HUNT: begin
                if (bad_hdr) begin
                    state_d = ST_SLIP;
                end else if (good_hdr && (good_cnt_q == GOOD_LAST)) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_SLIP: begin
                // SLIP lasts SLIP_WAIT cycles, pulse cycle included.
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                // Too many bad headers wins over a window wrap on the same header.
                if (bad_hdr && (bad_cnt_q == BAD_LAST)) begin
                    state_d = ST_SLIP;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // ------------------------------------------------------------------
    // Counter next values
    // ------------------------------------------------------------------
    always_comb begin
        good_cnt_d = good_cnt_q;
        win_cnt_d  = win_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        wait_cnt_d = '0;
        unique case (state_q)
            ST_HUNT: begin
                win_cnt_d = '0;
                bad_cnt_d = '0;
                if (bad_hdr) begin
                    good_cnt_d = '0;
                end else if (good_hdr) begin
                    // Cleared on lock so LOCKED starts from a clean slate.
                    good_cnt_d = (good_cnt_q == GOOD_LAST) ? '0 : good_cnt_q + GOOD_W'(1);
                end
            end
            ST_SLIP: begin
                // Headers are ignored here; the timer runs regardless of header_valid.
                good_cnt_d = '0;
                win_cnt_d  = '0;
                bad_cnt_d  = '0;
                wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? '0 : wait_cnt_q + WAIT_W'(1);
            end
            ST_LOCKED: begin
                good_cnt_d = '0;
                if (header_valid) begin
                    if ((bad_hdr && (bad_cnt_q == BAD_LAST)) || (win_cnt_q == WIN_LAST)) begin
                        win_cnt_d = '0;
                        bad_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        bad_cnt_d = bad_cnt_q + BAD_W'(bad_hdr);
                    end
                end
            end
            default: begin
                good_cnt_d = '0;
                win_cnt_d  = '0;
                bad_cnt_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        block_lock_d = (state_d == ST_LOCKED);
        // Pulse only on entry into SLIP, so one slip is outstanding at a time.
        rx_bitslip_d = (state_q != ST_SLIP) && (state_d == ST_SLIP);
    end

    assign block_lock     = block_lock_q;
    assign rx_bitslip     = rx_bitslip_q;
    // Uses the registered lock: the header that completes lock is not itself enabled.
    assign descrambler_en = block_lock_q & header_valid;

`ifdef BLOCK_LOCK_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] slip_cnt_q;
    logic [CNT_W-1:0] lock_loss_cnt_q;
    logic             lock_loss_evt;

    assign lock_loss_evt = (state_q == ST_LOCKED) && (state_d == ST_SLIP);

    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            slip_cnt_q      <= '0;
            lock_loss_cnt_q <= '0;
        end else begin
            if (rx_bitslip_d && (slip_cnt_q != '1)) begin
                slip_cnt_q <= slip_cnt_q + CNT_W'(1);
            end
            if (lock_loss_evt && (lock_loss_cnt_q != '1)) begin
                lock_loss_cnt_q <= lock_loss_cnt_q + CNT_W'(1);
            end
        end
    end

    assign slip_cnt      = slip_cnt_q;
    assign lock_loss_cnt = lock_loss_cnt_q;
`else
    // Statistics build option off: no counters, FSM unchanged.
`endif

endmodule

// File: doc/block_lock_ctrl.md
# block_lock_ctrl

64b/66b block-lock controller for the RX descrambler path. Inspects the 2-bit sync header of each received block, runs a Clause-49-style lock FSM, issues single-cycle bitslip requests to the gearbox while hunting, and gates the descrambler enable so that only blocks received under lock are descrambled. It sits between the RX gearbox (header/data source) and the `descrambler` instance, driving its `descrambler_en`.

## Interface
- `LOCK_COUNT`, 64: consecutive valid headers required to declare lock.
- `WINDOW`, 64: headers per bad-header monitoring window while locked.
- `BAD_MAX`, 16: invalid headers within one window that force loss of lock.
- `SLIP_WAIT`, 32: idle cycles after a bitslip before hunting resumes (gearbox settle time).
- `CNT_W`, 16: width of the statistics counters (used only with `BLOCK_LOCK_STATS_EN`).

- `USER_CLK`  in  1  block clock; 390.625 MHz in the SerDes RX domain.
- `SYSTEM_RESET`  in  1  synchronous, active-high reset.
- `sync_header`  in  2  sync header of the current block; 2'b01 and 2'b10 valid, 2'b00 and 2'b11 invalid.
- `header_valid`  in  1  `sync_header` is meaningful this cycle; the gearbox may stall.
- `rx_bitslip`  out  1  one-cycle pulse requesting a 1-bit slip from the gearbox.
- `block_lock`  out  1  registered lock status.
- `descrambler_en`  out  1  `block_lock & header_valid`, combinational; drives the descrambler enable.
- `slip_cnt`  out  CNT_W  saturating count of issued bitslips (macro only).
- `lock_loss_cnt`  out  CNT_W  saturating count of LOCKED->SLIP transitions (macro only).

## Operation
- States: HUNT, SLIP, LOCKED. Internal counters: `good_cnt` (ceil log2(LOCK_COUNT+1) bits), `win_cnt`, `bad_cnt`, `wait_cnt`.
- HUNT: on `header_valid` with a valid header, increment `good_cnt`. When the increment reaches LOCK_COUNT, go to LOCKED, set `block_lock`, and clear all counters. On `header_valid` with an invalid header, go to SLIP. Cycles without `header_valid` leave all counters unchanged.
- SLIP: `rx_bitslip` is high for the first cycle of SLIP only. `wait_cnt` counts SLIP_WAIT cycles regardless of `header_valid`, and headers are ignored during SLIP. Then go to HUNT with `good_cnt` = 0.
- LOCKED: each `header_valid` increments `win_cnt`; an invalid header also increments `bad_cnt`.
  - If `bad_cnt` reaches BAD_MAX: go to SLIP and clear `block_lock` on the same edge. This takes priority over a window wrap on the same header.
  - Otherwise, when `win_cnt` reaches WINDOW: clear both `win_cnt` and `bad_cnt`.
- Only one bitslip is outstanding at a time. A new slip can be issued no earlier than SLIP_WAIT+1 cycles after the previous one.
- Reset: state HUNT; all counters 0; `block_lock` = 0; `rx_bitslip` = 0; statistics counters = 0. Reset mid-operation (including mid-SLIP) aborts on the next edge; no pending bitslip survives reset.
- Statistics counters saturate at all-ones and never wrap.

## Timing
- Every output except `descrambler_en` is registered and changes one edge after the sampled header that causes the change.
- Lock latency from HUNT: `block_lock` rises on the edge that samples the LOCK_COUNT-th consecutive valid header.
- `rx_bitslip` is asserted in the cycle immediately after the edge that samples the offending header, and lasts exactly one cycle.
- Hunt restart: HUNT resumes SLIP_WAIT cycles after `rx_bitslip` rises (SLIP occupies SLIP_WAIT cycles including the pulse cycle).
- `descrambler_en` is zero-latency relative to `header_valid` and uses the registered `block_lock`. The block whose header completes lock is therefore not itself enabled.

## Configuration
- `BLOCK_LOCK_STATS_EN` defined: `slip_cnt` and `lock_loss_cnt` ports and their registers exist.
- `BLOCK_LOCK_STATS_EN` undefined: those ports and registers are absent. FSM behaviour and timing are identical in both builds.

## Test plan
All scenarios use default parameters.
- Reset, then 64 headers of 2'b01 with `header_valid`=1 -> `block_lock` rises after the 64th header; `rx_bitslip` never asserts; `descrambler_en` follows `header_valid` from the next cycle on.
- HUNT with 10 valid headers, then 2'b11 -> one-cycle `rx_bitslip`; no further slip for 32 cycles despite continued 2'b00 input; then a second slip; `slip_cnt`=2.
- Locked, then 15 invalid headers spread within one 64-header window -> lock held. 16th invalid header in the same window -> `block_lock` drops and `rx_bitslip` pulses on the same edge; `lock_loss_cnt`=1.
- Locked, 15 invalid headers in window N, then 15 in window N+1 -> lock held (counters clear at the wrap).
- `header_valid` toggling 1/0 during hunting with valid headers -> lock after exactly 64 valid-flagged headers (127 cycles); counters hold during gaps.
- `SYSTEM_RESET` asserted during SLIP at `wait_cnt`=5 -> next cycle in HUNT with `block_lock`=0 and `rx_bitslip`=0, and the statistics counters are cleared.
